// File: rtl/axi_lite_mem_responder_pkg.sv
// Shared types and sizing helpers for the AXI4-Lite memory responder.
// Holds response codes, the two FSM state encodings and index-width helpers.
// Imported by the responder top and its memory array.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_LAT  = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_LAT  = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  // Response latency counter width; covers RESP_LAT up to 15.
  localparam int unsigned LAT_W = 4;

  // Number of word-index bits for a memory of the given depth.
  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Number of byte-offset bits below the word index.
  function automatic int unsigned lsb_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/axi_lite_mem_responder_mem_array.sv
// Purpose: DEPTH x DATA_W storage, one byte-enable write port, one read port.
// Latency: read data appears the cycle after rd_en; write lands at the clock edge.
// Backpressure: none; read-first, so a same-cycle read sees the pre-write word.
module axi_lite_mem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned IDX_W  = 8
) (
  input  logic                clock,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  input  logic                rd_en,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [DATA_W-1:0]   rd_data
);

  localparam int unsigned NB = DATA_W / 8;

  // Contents start at zero and are deliberately never cleared by reset.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] rd_data_q = '0;
  logic [DATA_W-1:0] rd_data_d;

  // Read register only moves when a sample is requested, so data holds otherwise.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_idx];
    end
  end

  // Byte-lane writes and the read register share one edge, giving read-first.
  always_ff @(posedge clock) begin
    rd_data_q <= rd_data_d;
    for (int b = 0; b < NB; b++) begin
      if (wr_en && wr_strb[b]) begin
        mem_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_lite_mem_responder.sv
// Purpose: AXI4-Lite slave memory with DECERR outside its window and saturating stats.
// Latency: B/R valid RESP_LAT+1 cycles after request capture; one write and one read in flight.
// Backpressure: AW/W/AR readies drop from capture until the B/R handshake; B/R hold until ready.
module axi_lite_mem_responder
  import axi_lite_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       RESP_LAT  = 0,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [2:0]          awprot,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [2:0]          arprot,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready,
  output logic [CNT_W-1:0]    wr_count,
  output logic [CNT_W-1:0]    rd_count,
  output logic [CNT_W-1:0]    err_count
);

  localparam int unsigned       STRB_W   = DATA_W / 8;
  localparam int unsigned       LSB      = lsb_w(DATA_W);
  localparam int unsigned       IDX_W    = idx_w(DEPTH);
  localparam int unsigned       SPAN_W   = LSB + IDX_W;
  localparam logic [LAT_W-1:0]  LAT_INIT = LAT_W'(RESP_LAT);
  localparam logic [LAT_W-1:0]  LAT_ONE  = LAT_W'(1);

  // Base is aligned to the window size, so range check is an upper-bit compare.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:SPAN_W] == BASE_ADDR[ADDR_W-1:SPAN_W];
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, c} + {{(CNT_W-1){1'b0}}, inc};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // ---------------- write channel state ----------------
  wr_state_t           wr_state_q, wr_state_d;
  logic                aw_held_q, aw_held_d;
  logic                w_held_q, w_held_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [LAT_W-1:0]    wr_lat_q, wr_lat_d;
  logic                bvalid_q, bvalid_d;
  resp_t               bresp_q, bresp_d;

  // ---------------- read channel state ----------------
  rd_state_t           rd_state_q, rd_state_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [LAT_W-1:0]    rd_lat_q, rd_lat_d;
  logic                rvalid_q, rvalid_d;
  resp_t               rresp_q, rresp_d;

  // ---------------- statistics ----------------
  logic [CNT_W-1:0]    wr_count_q, wr_count_d;
  logic [CNT_W-1:0]    rd_count_q, rd_count_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;

  logic                aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic                wr_commit, wr_in_range, mem_we;
  logic                rd_sample, rd_in_range;
  logic [ADDR_W-1:0]   eff_waddr, eff_raddr;
  logic [DATA_W-1:0]   eff_wdata, mem_rdata;
  logic [STRB_W-1:0]   eff_wstrb;
  logic [1:0]          err_inc;
  logic                unused_ok;

  // Readies are pure functions of state; reset forces them low immediately.
  assign awready = !reset && (wr_state_q == W_IDLE) && !aw_held_q;
  assign wready  = !reset && (wr_state_q == W_IDLE) && !w_held_q;
  assign arready = !reset && (rd_state_q == R_IDLE);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;
  assign b_hs  = bvalid_q && bready;
  assign r_hs  = rvalid_q && rready;

  // Commit uses the beat arriving now if it has not been latched yet.
  assign eff_waddr   = aw_held_q ? awaddr_q : awaddr;
  assign eff_wdata   = w_held_q  ? wdata_q  : wdata;
  assign eff_wstrb   = w_held_q  ? wstrb_q  : wstrb;
  assign eff_raddr   = (rd_state_q == R_IDLE) ? araddr : araddr_q;
  assign wr_in_range = in_range(eff_waddr);
  assign rd_in_range = in_range(eff_raddr);
  // Reset aborts a pending write, so never let a commit slip through it.
  assign mem_we      = wr_commit && wr_in_range && !reset;

  // Write FSM: collect AW and W independently, wait out the latency, then respond.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wr_lat_d   = wr_lat_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_commit  = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = awaddr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = wdata;
          wstrb_d  = wstrb;
        end
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          if (RESP_LAT == 0) begin
            wr_commit = 1'b1;
          end else begin
            wr_state_d = W_LAT;
            wr_lat_d   = LAT_INIT;
          end
        end
      end
      W_LAT: begin
        wr_lat_d = wr_lat_q - LAT_ONE;
        if (wr_lat_q == LAT_ONE) begin
          wr_commit = 1'b1;
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d   = 1'b0;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
    if (wr_commit) begin
      wr_state_d = W_RESP;
      bvalid_d   = 1'b1;
      bresp_d    = wr_in_range ? OKAY : DECERR;
    end
  end

  // Read FSM: latch AR, wait out the latency, sample memory on entry to R_DATA.
  always_comb begin
    rd_state_d = rd_state_q;
    araddr_d   = araddr_q;
    rd_lat_d   = rd_lat_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rd_sample  = 1'b0;
    unique case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          araddr_d = araddr;
          if (RESP_LAT == 0) begin
            rd_sample = 1'b1;
          end else begin
            rd_state_d = R_LAT;
            rd_lat_d   = LAT_INIT;
          end
        end
      end
      R_LAT: begin
        rd_lat_d = rd_lat_q - LAT_ONE;
        if (rd_lat_q == LAT_ONE) begin
          rd_sample = 1'b1;
        end
      end
      R_DATA: begin
        if (rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
    if (rd_sample) begin
      rd_state_d = R_DATA;
      rvalid_d   = 1'b1;
      rresp_d    = rd_in_range ? OKAY : DECERR;
    end
  end

  // Statistics: count handshakes, two DECERRs in one cycle add two, all saturate.
  always_comb begin
    err_inc     = {1'b0, b_hs && (bresp_q == DECERR)} + {1'b0, r_hs && (rresp_q == DECERR)};
    wr_count_d  = sat_add(wr_count_q, {1'b0, b_hs});
    rd_count_d  = sat_add(rd_count_q, {1'b0, r_hs});
    err_count_d = sat_add(err_count_q, err_inc);
  end

  // Write channel registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state_q <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wr_lat_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wr_lat_q   <= wr_lat_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
    end
  end

  // Read channel registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state_q <= R_IDLE;
      araddr_q   <= '0;
      rd_lat_q   <= '0;
      rvalid_q   <= 1'b0;
      rresp_q    <= OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      araddr_q   <= araddr_d;
      rd_lat_q   <= rd_lat_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
    end
  end

  // Statistics registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_count_q  <= '0;
      rd_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      wr_count_q  <= wr_count_d;
      rd_count_q  <= rd_count_d;
      err_count_q <= err_count_d;
    end
  end

  axi_lite_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clock   (clock),
    .wr_en   (mem_we),
    .wr_idx  (eff_waddr[LSB +: IDX_W]),
    .wr_data (eff_wdata),
    .wr_strb (eff_wstrb),
    .rd_en   (rd_sample),
    .rd_idx  (eff_raddr[LSB +: IDX_W]),
    .rd_data (mem_rdata)
  );

  assign bvalid    = bvalid_q;
  assign bresp     = bresp_q;
  assign rvalid    = rvalid_q;
  assign rresp     = rresp_q;
  // Array register is not reset; gate it so idle and DECERR beats read as zero.
  assign rdata     = (rvalid_q && (rresp_q == OKAY)) ? mem_rdata : '0;
  assign wr_count  = wr_count_q;
  assign rd_count  = rd_count_q;
  assign err_count = err_count_q;

  // Protection bits and sub-word address bits carry no meaning here.
  assign unused_ok = ^{awprot, arprot, eff_waddr[LSB-1:0], eff_raddr[LSB-1:0]};

endmodule

// File: doc/axi_lite_mem_responder.md
Name: axi_lite_mem_responder

Overview:
Synthesisable AXI4-Lite slave memory model that replaces the runtime-slave VIP memory model in example benches. It sits behind a master VIP or passthrough VIP on the chip's AXI port. It supports parametrised data width, depth, base address and response latency. It adds out-of-range DECERR responses and saturating transaction/error counters for scoreboarding.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, data width (32 or 64)
DEPTH, 256, number of DATA_W words (power of two)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (aligned to DEPTH*DATA_W/8)
RESP_LAT, 0, extra idle cycles between request capture and bvalid/rvalid (0..15)
CNT_W, 16, width of statistics counters

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
awaddr  in  ADDR_W  write address
awprot  in  3  ignored
awvalid / awready  in / out  1  AW handshake
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  byte strobes
wvalid / wready  in / out  1  W handshake
bresp  out  2  write response
bvalid / bready  out / in  1  B handshake
araddr  in  ADDR_W  read address
arprot  in  3  ignored
arvalid / arready  in / out  1  AR handshake
rdata  out  DATA_W  read data
rresp  out  2  read response
rvalid / rready  out / in  1  R handshake
wr_count  out  CNT_W  completed B handshakes
rd_count  out  CNT_W  completed R handshakes
err_count  out  CNT_W  completed handshakes carrying DECERR

Behaviour:
- Reset: clock and reset are a single clock with a synchronous, active-high reset.
  - While reset=1: awready, wready, arready, bvalid and rvalid are 0; bresp, rresp and rdata are 0; all counters are 0; both FSMs return to IDLE.
  - Memory contents are not cleared. Memory is initialised to zero at time 0 only.
  - Reset mid-transaction aborts it silently. A write whose B was not yet issued is not committed.
- Word index is addr[LSB +: log2(DEPTH)], where LSB = log2(DATA_W/8). Low LSB bits are ignored.
- An address is in range iff BASE_ADDR <= addr < BASE_ADDR + DEPTH*DATA_W/8.
- Write FSM states: W_IDLE, W_LAT, W_RESP.
  - W_IDLE: awready=1 until AW is captured, and wready=1 until W is captured. AW and W may arrive in either order or in the same cycle; each is latched independently.
  - When both are held, the FSM goes to W_LAT with a latency counter = RESP_LAT. If RESP_LAT=0, it goes straight to W_RESP.
  - W_LAT: the counter decrements each cycle. At 0 the FSM goes to W_RESP.
  - Entering W_RESP: commit the write (bytes with wstrb=1 only, in range only) and set bvalid=1. bresp=OKAY if in range, else DECERR with no memory change.
  - W_RESP: bvalid holds, with bresp stable, until bready. On the handshake the FSM returns to W_IDLE.
  - AW/W readies stay 0 from capture until the B handshake completes: one outstanding write.
  - Minimum latency, with RESP_LAT=0, AW and W in cycle N and bready=1: bvalid in cycle N+1, W_IDLE again in N+2.
- Read FSM states: R_IDLE, R_LAT, R_DATA.
  - R_IDLE: arready=1. On the AR handshake the FSM latches the address and goes to R_LAT, or to R_DATA if RESP_LAT=0.
  - Entering R_DATA: sample the memory word and set rvalid=1. rresp=OKAY, or DECERR with rdata=0 if out of range.
  - R_DATA: rdata and rresp are held stable until rready. On the handshake the FSM returns to R_IDLE. arready=0 outside R_IDLE.
- Read/write collision: if a write commit and a read sample hit the same word in the same cycle, the read returns the pre-write data (read-first).
- Read and write FSMs are fully independent; simultaneous AW/W/AR in one cycle are all accepted.
- Counters increment on the handshake cycle and saturate at all-ones.
  - err_count increments on each DECERR B or R handshake.
  - Simultaneous B and R DECERR handshakes in one cycle add 2, still saturating.
- Valid/ready rules: bvalid and rvalid never drop without a handshake. No output depends combinationally on any *valid or *ready input.

Decomposition:
- Package axi_lite_pkg contains:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - wr_state_t and rd_state_t enums.
  - Functions idx_w(DEPTH) and lsb_w(DATA_W).
- Sub-module axi_lite_mem_array: one byte-enable write port and one read port, read-first, synchronous, DEPTH x DATA_W, zero-initialised.

Test Plan:
- Reset, then AW+W together: addr 0x10, data 0xDEADBEEF, wstrb 0xF, bready=1. Expect bvalid exactly 1 cycle later with bresp=OKAY. Then AR 0x10: rdata=0xDEADBEEF, rresp=OKAY, wr_count=1, rd_count=1.
- W sent 3 cycles before AW, wstrb=0x3, data 0x0000_1234, over a word holding 0xDEADBEEF. Expect a single B only after AW, and readback 0xDEAD1234.
- Write and read to 0x400 with DEPTH=256, DATA_W=32. Expect bresp=DECERR with memory unchanged, rresp=DECERR with rdata=0, and err_count=2.
- RESP_LAT=5 with bready held 0 for 4 cycles after bvalid. Expect bvalid rises 6 cycles after capture and stays stable with bresp unchanged; awready=0 throughout.
- Same-cycle write commit and read sample to 0x20 (old value 0x1, new value 0x2). Expect rdata=0x1, then a subsequent read returns 0x2.
- Assert reset while in W_LAT, then read the target address. Expect bvalid never rises and the old data is returned. Separately force wr_count to all-ones and write once more: wr_count stays all-ones.
